// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, default widths
// and the program-loader state encoding.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADRS_W = 8;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_LD   = 8'h02;
  localparam logic [7:0] OP_ADDI = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_ST   = 8'h05;
  localparam logic [7:0] OP_JMP  = 8'h06;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } loader_state_t;

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x W storage with synchronous write and enabled synchronous read;
// rdata holds its value on cycles without a read.
module prog_mem_array #(
  parameter int W     = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_mem.sv
// Loadable program memory: one-cycle fetch port plus streaming loader FSM.
// Optional parity checking is enabled with macro PROG_MEM_PARITY_EN.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADRS_W = CPU_ADRS_W,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADRS_W-1:0] adrs,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  output logic              rd_err,
  input  logic              ld_start,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_ovf,
  output logic [ADRS_W:0]   prog_len,
  output logic              busy,
`ifdef PROG_MEM_PARITY_EN
  output logic              perr,
`endif
  output loader_state_t     dbg_state
);

  // Loader handshake: a word transfers on a rising edge where ld_valid and
  // ld_ready are both high; ld_ready never depends on ld_valid.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PROG_MEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam logic [ADRS_W:0] DEPTH_L = DEPTH[ADRS_W:0];

  loader_state_t   state;
  logic [ADRS_W:0] ptr;
  logic [ADRS_W:0] adrs_x;
  logic            fill_q;
  logic            accept;
  logic            fetch;
  logic            in_range;
  logic            hit;
  logic [MW-1:0]   wdata;
  logic [MW-1:0]   rdata;

  assign adrs_x    = {1'b0, adrs};
  assign busy      = (state == LOAD);
  assign ld_ready  = busy && (ptr < DEPTH_L);
  assign accept    = ld_valid && ld_ready && !ld_start;
  assign fetch     = rd && !busy;
  assign in_range  = (adrs_x < DEPTH_L);
  assign hit       = fetch && (adrs_x < prog_len);
  assign dbg_state = state;

`ifdef PROG_MEM_PARITY_EN
  assign wdata = {^ld_data, ld_data};
  assign perr  = dvalid && !fill_q && (^rdata);
`else
  assign wdata = ld_data;
`endif

  prog_mem_array #(
    .W     (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (accept),
    .waddr (ptr[AW-1:0]),
    .wdata (wdata),
    .re    (hit),
    .raddr (adrs[AW-1:0]),
    .rdata (rdata)
  );

  // Restart has priority over an accepted word in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      prog_len <= '0;
      ld_ovf   <= 1'b0;
    end else if (ld_start) begin
      state    <= LOAD;
      ptr      <= '0;
      prog_len <= '0;
      ld_ovf   <= 1'b0;
    end else if (state == LOAD && ld_valid) begin
      if (ld_ready) begin
        ptr      <= ptr + 1'b1;
        prog_len <= ptr + 1'b1;
      end else begin
        ld_ovf <= 1'b1;
      end
      if (ld_last) state <= IDLE;
    end
  end

  // fill_q marks reads that return the NOP fill instead of array data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvalid <= 1'b0;
      rd_err <= 1'b0;
      fill_q <= 1'b1;
    end else begin
      dvalid <= fetch;
      rd_err <= fetch && !in_range;
      if (fetch) fill_q <= !hit;
    end
  end

  assign dout = fill_q ? '0 : rdata[DATA_W-1:0];

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: fetch latency, loading, overflow, busy
// lockout, reset mid-load, restart priority and optional parity.
module tb_prog_mem;
  import cpu_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADRS_W = 8;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADRS_W-1:0] adrs;
  logic              rd;
  logic [DATA_W-1:0] dout;
  logic              dvalid;
  logic              rd_err;
  logic              ld_start;
  logic [DATA_W-1:0] ld_data;
  logic              ld_valid;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_ovf;
  logic [ADRS_W:0]   prog_len;
  logic              busy;
`ifdef PROG_MEM_PARITY_EN
  logic              perr;
`endif
  loader_state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] sum_prog [22] = '{8'h01, 8'h00, 8'h05, 8'h21, 8'h01, 8'h00, 8'h05, 8'h20,
                                8'h03, 8'h01, 8'h05, 8'h20, 8'h02, 8'h21, 8'h04, 8'h20,
                                8'h05, 8'h21, 8'h02, 8'h20, 8'h06, 8'h08};

  prog_mem #(.DATA_W(DATA_W), .ADRS_W(ADRS_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .adrs      (adrs),
    .rd        (rd),
    .dout      (dout),
    .dvalid    (dvalid),
    .rd_err    (rd_err),
    .ld_start  (ld_start),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_ovf    (ld_ovf),
    .prog_len  (prog_len),
    .busy      (busy),
`ifdef PROG_MEM_PARITY_EN
    .perr      (perr),
`endif
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [7:0] a, input logic [7:0] exp_d, input logic exp_err, input string tag);
    adrs = a;
    rd   = 1'b1;
    step();
    rd = 1'b0;
    check({tag, "_dout"}, dout, exp_d);
    check({tag, "_dvalid"}, dvalid, 1);
    check({tag, "_rd_err"}, rd_err, exp_err);
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    check("start_busy", busy, 1);
    check("start_state", dbg_state, LOAD);
    check("start_len", prog_len, 0);
  endtask

  initial begin
    rst = 1'b1; adrs = '0; rd = 1'b0;
    ld_start = 1'b0; ld_data = '0; ld_valid = 1'b0; ld_last = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_dvalid", dvalid, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_ld_ovf", ld_ovf, 0);
    check("rst_len", prog_len, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, IDLE);

    // Empty program: everything reads as NOP fill.
    for (int a = 0; a < 4; a++) fetch(a[7:0], 8'h00, 1'b0, "empty");
    step();
    check("idle_dvalid", dvalid, 0);
    check("empty_len", prog_len, 0);

    // Load the sum loop program.
    start_load();
    for (int i = 0; i < 22; i++) begin
      check("sum_ready", ld_ready, 1);
      ld_valid = 1'b1;
      ld_data  = sum_prog[i];
      ld_last  = (i == 21);
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("sum_busy", busy, 0);
    check("sum_len", prog_len, 22);
    fetch(8'h14, 8'h06, 1'b0, "f14");
    fetch(8'h15, 8'h08, 1'b0, "f15");
    fetch(8'h16, 8'h00, 1'b0, "f16");
    fetch(8'h00, 8'h01, 1'b0, "f00");
    fetch(8'h03, 8'h21, 1'b0, "f03");
    step();
    check("hold_dvalid", dvalid, 0);
    check("hold_dout", dout, 8'h21);

    // Out of range: NOP with a single-cycle error pulse.
    fetch(8'h20, 8'h00, 1'b1, "f20");
    step();
    check("f20_err_pulse", rd_err, 0);
    check("f20_dvalid_off", dvalid, 0);
    fetch(8'hFF, 8'h00, 1'b1, "fFF");

`ifdef PROG_MEM_PARITY_EN
    dut.u_array.mem[2] = dut.u_array.mem[2] ^ 9'h001;
    fetch(8'h02, 8'h04, 1'b0, "par02");
    check("par02_perr", perr, 1);
    fetch(8'h01, 8'h00, 1'b0, "par01");
    check("par01_perr", perr, 0);
    fetch(8'h16, 8'h00, 1'b0, "par16");
    check("par16_perr", perr, 0);
    fetch(8'h20, 8'h00, 1'b1, "par20");
    check("par20_perr", perr, 0);
`endif

    // Overflow: 32 accepted words then extra offers set the sticky flag.
    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_ready", ld_ready, 1);
      ld_valid = 1'b1;
      ld_data  = 8'h40 + i[7:0];
      step();
    end
    check("full_ready", ld_ready, 0);
    check("full_len", prog_len, 32);
    check("full_ovf", ld_ovf, 0);
    ld_data = 8'hEE;
    step();
    check("ovf_flag", ld_ovf, 1);
    check("ovf_busy", busy, 1);
    check("ovf_len", prog_len, 32);
    ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("ovf_exit_busy", busy, 0);
    check("ovf_sticky", ld_ovf, 1);
    check("ovf_exit_len", prog_len, 32);
    fetch(8'h1F, 8'h5F, 1'b0, "ovf1F");
    fetch(8'h00, 8'h40, 1'b0, "ovf00");

    // Fetches are ignored while loading; reset mid-load clears the program.
    start_load();
    check("restart_ovf_clr", ld_ovf, 0);
    rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      adrs     = (i == 2) ? 8'h20 : 8'h00;
      ld_valid = 1'b1;
      ld_data  = 8'h70 + i[7:0];
      step();
      check("busy_dvalid", dvalid, 0);
      check("busy_rd_err", rd_err, 0);
    end
    rd = 1'b0; ld_valid = 1'b0;
    check("mid_len", prog_len, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_len", prog_len, 0);
    fetch(8'h00, 8'h00, 1'b0, "midrst00");

    // A restart in the same cycle as an offered word drops the word.
    start_load();
    ld_valid = 1'b1; ld_data = 8'h11;
    step();
    check("rs_len1", prog_len, 1);
    ld_start = 1'b1; ld_data = 8'h22;
    step();
    ld_start = 1'b0;
    check("rs_len0", prog_len, 0);
    check("rs_busy", busy, 1);
    ld_data = 8'h33; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("rs_len_final", prog_len, 1);
    check("rs_idle", busy, 0);
    fetch(8'h00, 8'h33, 1'b0, "rs00");
    fetch(8'h01, 8'h00, 1'b0, "rs01");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
